i2c_slave_rx: RTL and testbench

- Write-only I2C slave receiver; consumes the scl/sda lines produced by the I2C master top level.
- Detects START/STOP, shifts in address and data bytes, and drives ACK open-drain.
- Presents each received byte on a parallel interface with a one-cycle valid strobe.
- Serves as the on-chip bus target for master bring-up and for the loopback testbench.

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_sync_edge.sv | 40 ++++
 rtl/i2c_slave_rx.sv | 152 +++++++++++++++
 tb/tb_i2c_slave_rx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and widths for the write-only I2C slave receiver.
package i2c_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BIT_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall pulses and a level aligned to them.
module i2c_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic ck,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  // Flops reset low so a released idle bus can only look like STOP, never START.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_hist <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_hist <= w_synced;
      r_rise <= w_synced & ~r_hist;
      r_fall <= ~w_synced & r_hist;
    end
  end

  assign o_level = r_hist;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave: decodes START/STOP, matches address, ACKs and delivers data bytes.
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic              ck,
  input  logic              reset,
  input  logic              scl,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [ADDR_W-1:0] rx_addr,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic [CNT_W-1:0]  rx_count,
  output logic              busy
);

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;
  logic [DATA_W-1:0] w_byte;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .ck(ck), .reset(reset), .i_async(scl),
    .o_level(w_scl_lvl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .ck(ck), .reset(reset), .i_async(sda_in),
    .o_level(w_sda_lvl), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  state_t              r_state, w_state_nx;
  logic [BIT_W-1:0]    r_bit, w_bit_nx;
  logic [DATA_W-2:0]   r_shift, w_shift_nx;
  logic                r_ack_drv, w_ack_drv_nx;
  logic                r_sda_oe, w_sda_oe_nx;
  logic [ADDR_W-1:0]   r_addr, w_addr_nx;
  logic [DATA_W-1:0]   r_data, w_data_nx;
  logic                r_valid, w_valid_nx;
  logic [CNT_W-1:0]    r_count, w_count_nx;
  logic                r_busy, w_busy_nx;

  assign w_start = w_sda_fall & w_scl_lvl;
  assign w_stop  = w_sda_rise & w_scl_lvl;
  assign w_byte  = {r_shift, w_sda_lvl};

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_bit     <= '0;
      r_shift   <= '0;
      r_ack_drv <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_count   <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_bit     <= w_bit_nx;
      r_shift   <= w_shift_nx;
      r_ack_drv <= w_ack_drv_nx;
      r_sda_oe  <= w_sda_oe_nx;
      r_addr    <= w_addr_nx;
      r_data    <= w_data_nx;
      r_valid   <= w_valid_nx;
      r_count   <= w_count_nx;
      r_busy    <= w_busy_nx;
    end
  end

  // Bus conditions override bit activity; ACK drive only moves on scl falls.
  always_comb begin
    w_state_nx   = r_state;
    w_bit_nx     = r_bit;
    w_shift_nx   = r_shift;
    w_ack_drv_nx = r_ack_drv;
    w_sda_oe_nx  = r_sda_oe;
    w_addr_nx    = r_addr;
    w_data_nx    = r_data;
    w_valid_nx   = 1'b0;
    w_count_nx   = r_count;
    w_busy_nx    = r_busy;

    if (w_start) begin
      w_state_nx   = ADDR;
      w_bit_nx     = '0;
      w_ack_drv_nx = 1'b0;
      w_sda_oe_nx  = 1'b0;
      w_busy_nx    = 1'b0;
    end else if (w_stop) begin
      w_state_nx   = IDLE;
      w_bit_nx     = '0;
      w_ack_drv_nx = 1'b0;
      w_sda_oe_nx  = 1'b0;
      w_busy_nx    = 1'b0;
    end else begin
      case (r_state)
        ADDR, DATA: begin
          if (w_scl_rise) begin
            w_shift_nx = w_byte[DATA_W-2:0];
            w_bit_nx   = r_bit + BIT_W'(1);
            if (r_bit == BIT_W'(7)) begin
              w_ack_drv_nx = 1'b0;
              if (r_state == ADDR) begin
                if (w_byte[DATA_W-1:1] == SLAVE_ADDR && !w_byte[0]) begin
                  w_addr_nx  = w_byte[DATA_W-1:1];
                  w_count_nx = '0;
                  w_state_nx = ADDR_ACK;
                end else begin
                  w_state_nx = IGNORE;
                end
              end else begin
                w_data_nx  = w_byte;
                w_valid_nx = 1'b1;
                if (r_count != {CNT_W{1'b1}}) w_count_nx = r_count + CNT_W'(1);
                w_state_nx = DATA_ACK;
              end
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_drv) begin
              w_ack_drv_nx = 1'b1;
              w_sda_oe_nx  = 1'b1;
            end else begin
              w_ack_drv_nx = 1'b0;
              w_sda_oe_nx  = 1'b0;
              w_busy_nx    = 1'b1;
              w_bit_nx     = '0;
              w_state_nx   = DATA;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe   = r_sda_oe;
  assign rx_addr  = r_addr;
  assign rx_data  = r_data;
  assign rx_valid = r_valid;
  assign rx_count = r_count;
  assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-banged I2C master plus a transaction-level expectation model.
module tb_i2c_slave_rx;

  localparam logic [6:0] SLV = 7'h50;
  localparam int unsigned QTR = 8;

  logic       ck;
  logic       reset;
  logic       m_scl;
  logic       m_sda;
  logic       sda_in;
  logic       sda_oe;
  logic [6:0] rx_addr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] rx_count;
  logic       busy;

  // Open-drain bus: slave pulls low, master drives or releases high.
  assign sda_in = m_sda & ~sda_oe;

  i2c_slave_rx #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .ck(ck), .reset(reset), .scl(m_scl), .sda_in(sda_in),
    .sda_oe(sda_oe), .rx_addr(rx_addr), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_count(rx_count), .busy(busy)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] q_got[$];
  logic [3:0] q_cnt[$];
  int ack_edges = 0;
  int oe_viol = 0;
  logic prev_oe = 1'b0;
  logic [7:0] tx[32];

  logic [7:0] exp_data = 8'h00;
  logic [6:0] exp_addr = 7'h00;
  int exp_count = 0;

  always @(negedge ck) begin
    if (rx_valid === 1'b1) begin
      q_got.push_back(rx_data);
      q_cnt.push_back(rx_count);
    end
    if (sda_oe === 1'b1 && prev_oe === 1'b0) ack_edges++;
    if (sda_oe !== prev_oe && m_scl === 1'b1) oe_viol++;
    prev_oe = sda_oe;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic qd();
    repeat (QTR) @(negedge ck);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; qd();
    m_scl = 1'b1; qd();
    m_sda = 1'b0; qd();
    m_scl = 1'b0; qd();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; qd();
    m_scl = 1'b1; qd();
    m_sda = 1'b1; qd();
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; qd();
    m_scl = 1'b1; qd(); qd();
    m_scl = 1'b0; qd();
  endtask

  task automatic ack_bit(output logic ack);
    m_sda = 1'b1; qd();
    m_scl = 1'b1; qd();
    ack = sda_in; qd();
    m_scl = 1'b0; qd();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    ack_bit(ack);
  endtask

  task automatic clear_mon();
    q_got.delete();
    q_cnt.delete();
    ack_edges = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, " rx_data"}, 32'(rx_data), 32'(exp_data));
    chk({tag, " rx_addr"}, 32'(rx_addr), 32'(exp_addr));
    chk({tag, " rx_count"}, 32'(rx_count), 32'(exp_count));
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " sda_oe"}, 32'(sda_oe), 32'd0);
  endtask

  // Full write transaction; expectations come from the address rule alone.
  task automatic xfer(input string tag, input logic [7:0] abyte, input int n);
    logic ack;
    bit   match;
    int   got;
    match = (abyte == {SLV, 1'b0});
    clear_mon();
    i2c_start();
    write_byte(abyte, ack);
    chk({tag, " addr ack"}, 32'(ack), match ? 32'd0 : 32'd1);
    chk({tag, " busy"}, 32'(busy), match ? 32'd1 : 32'd0);
    for (int i = 0; i < n; i++) begin
      write_byte(tx[i], ack);
      chk({tag, " data ack"}, 32'(ack), match ? 32'd0 : 32'd1);
    end
    i2c_stop();
    repeat (10) @(negedge ck);
    if (match) begin
      exp_addr  = SLV;
      exp_count = (n > 15) ? 15 : n;
      if (n > 0) exp_data = tx[n-1];
    end
    got = q_got.size();
    chk({tag, " valid pulses"}, 32'(got), match ? 32'(n) : 32'd0);
    for (int i = 0; i < got && i < n; i++) begin
      chk({tag, " byte"}, 32'(q_got[i]), 32'(tx[i]));
      chk({tag, " count"}, 32'(q_cnt[i]), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    chk({tag, " acks"}, 32'(ack_edges), match ? 32'(n + 1) : 32'd0);
    check_regs(tag);
  endtask

  initial begin
    logic ack;
    logic [7:0] ab;
    int n;

    reset = 1'b0;
    m_scl = 1'b1;
    m_sda = 1'b1;
    repeat (5) @(negedge ck);
    chk("reset sda_oe", 32'(sda_oe), 32'd0);
    chk("reset rx_valid", 32'(rx_valid), 32'd0);
    check_regs("reset");
    reset = 1'b1;
    repeat (10) @(negedge ck);

    tx[0] = 8'h3C;
    xfer("wrong_addr", {7'h51, 1'b0}, 1);
    tx[0] = 8'h55;
    xfer("read_bit", 8'hA1, 1);
    tx[0] = 8'hA5;
    xfer("single", 8'hA0, 1);
    tx[0] = 8'h12; tx[1] = 8'h34; tx[2] = 8'h56;
    xfer("three", 8'hA0, 3);

    // Repeated START after a partial data byte.
    clear_mon();
    i2c_start();
    write_byte(8'hA0, ack);
    chk("rstart addr1 ack", 32'(ack), 32'd0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_start();
    write_byte(8'hA0, ack);
    chk("rstart addr2 ack", 32'(ack), 32'd0);
    write_byte(8'h77, ack);
    chk("rstart data ack", 32'(ack), 32'd0);
    i2c_stop();
    repeat (10) @(negedge ck);
    chk("rstart pulses", 32'(q_got.size()), 32'd1);
    if (q_got.size() > 0) chk("rstart byte", 32'(q_got[0]), 32'h77);
    chk("rstart acks", 32'(ack_edges), 32'd3);
    exp_data = 8'h77; exp_addr = SLV; exp_count = 1;
    check_regs("rstart");

    // Reset during bit 5 of a data byte; master then finishes the byte.
    i2c_start();
    write_byte(8'hA0, ack);
    chk("rst addr ack", 32'(ack), 32'd0);
    send_bit(1'b1); send_bit(1'b1);
    m_sda = 1'b0; qd();
    reset = 1'b0;
    repeat (3) @(negedge ck);
    exp_data = 8'h00; exp_addr = 7'h00; exp_count = 0;
    chk("rst rx_valid", 32'(rx_valid), 32'd0);
    check_regs("rst mid");
    reset = 1'b1;
    repeat (2) @(negedge ck);
    clear_mon();
    m_scl = 1'b1; qd(); qd();
    m_scl = 1'b0; qd();
    for (int i = 4; i >= 0; i--) send_bit(1'b1);
    ack_bit(ack);
    chk("rst after ack", 32'(ack), 32'd1);
    i2c_stop();
    repeat (10) @(negedge ck);
    chk("rst pulses", 32'(q_got.size()), 32'd0);
    chk("rst acks", 32'(ack_edges), 32'd0);
    check_regs("rst after");

    // Randomized transactions.
    for (int k = 0; k < 6; k++) begin
      case ($urandom_range(0, 3))
        0, 1:    ab = 8'hA0;
        2:       ab = 8'hA1;
        default: ab = 8'($urandom_range(0, 255));
      endcase
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) tx[i] = 8'($urandom_range(0, 255));
      xfer("random", ab, n);
    end

    // Count saturation past 15 bytes.
    for (int i = 0; i < 17; i++) tx[i] = 8'($urandom_range(0, 255));
    xfer("saturate", 8'hA0, 17);

    chk("oe moved with scl high", 32'(oe_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
